// File: rtl/regfile_pkg.sv
// Shared constants and bus-slicing helpers for the multi-port scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // LSB position of port k inside a packed multi-port bus of w-bit lanes
    function automatic int port_slice_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: claim at issue, release at writeback, claim wins a same-cycle tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 claim_en,
    input  logic [ADDR_W-1:0]    claim_addr,
    input  logic                 wr0_en,
    input  logic [ADDR_W-1:0]    wr0_addr,
    input  logic                 wr1_en,
    input  logic [ADDR_W-1:0]    wr1_addr,
    output logic [2**ADDR_W-1:0] busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: the newer producer (claim) outranks the retiring one (write)
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (claim_en && (claim_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((wr0_en && (wr0_addr == ADDR_W'(i))) ||
                         (wr1_en && (wr1_addr == ADDR_W'(i)))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[REG_ZERO] = 1'b0;
        end else begin
            busy_d[REG_ZERO] = busy_d[REG_ZERO];
        end
    end

    // Busy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= {DEPTH{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Dual-write, multi-read register file with write-to-read bypass and busy scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .busy_vec   (busy_vec)
    );

    // Storage next state: wr1 is applied last so it wins an address collision
    always_comb begin
        mem_d = mem_q;
        if (wr0_en) begin
            mem_d[wr0_addr] = wr0_data;
        end else begin
            mem_d = mem_d;
        end
        if (wr1_en) begin
            mem_d[wr1_addr] = wr1_data;
        end else begin
            mem_d = mem_d;
        end
        if (ZERO_REG != 0) begin
            mem_d[REG_ZERO] = {DATA_W{1'b0}};
        end else begin
            mem_d = mem_d;
        end
    end

    // Storage register array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int A_LSB = port_slice_lsb(k, ADDR_W);
        localparam int D_LSB = port_slice_lsb(k, DATA_W);

        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s = rd_addr[A_LSB +: ADDR_W];

        // Read mux: a same-cycle write is forwarded and hides the busy flag
        always_comb begin
            data_s = mem_q[addr_s];
            busy_s = busy_vec[addr_s];
            if ((ZERO_REG != 0) && (addr_s == ADDR_W'(REG_ZERO))) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (wr1_en && (wr1_addr == addr_s)) begin
                data_s = wr1_data;
                busy_s = 1'b0;
            end else if (wr0_en && (wr0_addr == addr_s)) begin
                data_s = wr0_data;
                busy_s = 1'b0;
            end else begin
                data_s = mem_q[addr_s];
                busy_s = busy_vec[addr_s];
            end
        end

        assign rd_data[D_LSB +: DATA_W] = data_s;
        assign rd_busy[k]               = busy_s;
    end

endmodule
